// File: rtl/map_cpu_sync_pkg.sv
// Shared types and constants for the cartridge CPU bus front-end.
package map_cpu_sync_pkg;

  // Bus-cycle tracker states
  typedef enum logic [1:0] {
    ST_LOW  = 2'd0,
    ST_HIGH = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int DEF_FILT    = 2;
  localparam int DEF_WR_DLY  = 8;
  localparam int DEF_IDLE_TO = 255;

  localparam int DLY_W  = 5;
  localparam int IDLE_W = 16;
  localparam int FILT_W = 3;

endpackage

// File: rtl/map_cpu_sync_if.sv
// Raw cartridge CPU pins plus the cleaned single-clock bus view.
interface map_cpu_sync_if;
  import map_cpu_sync_pkg::*;

  logic        pin_m2;
  logic        pin_rw;
  logic [15:0] pin_addr;
  logic [7:0]  pin_data;

  logic        m2;
  logic [15:0] addr;
  logic        rw;
  logic [7:0]  data;
  logic        m2_rise;
  logic        m2_fall;
  logic        wr_pulse;
  logic        wr_early;
  logic        m2_lost;

  // Cartridge side: drives the raw pins, observes the clean view
  modport master (
    output pin_m2, pin_rw, pin_addr, pin_data,
    input  m2, addr, rw, data, m2_rise, m2_fall, wr_pulse, wr_early, m2_lost
  );

  // Front-end side: samples the raw pins, produces the clean view
  modport slave (
    input  pin_m2, pin_rw, pin_addr, pin_data,
    output m2, addr, rw, data, m2_rise, m2_fall, wr_pulse, wr_early, m2_lost
  );
endinterface

// File: rtl/map_cpu_sync_sync_filt.sv
// Two-flop synchronizer followed by a debounce filter. The filtered level
// only follows the input after FILT consecutive differing samples.
// rise_nxt/fall_nxt flag that the level toggles at the coming clock edge,
// so a consumer can register an edge pulse aligned with the level change.
module sync_filt
  import map_cpu_sync_pkg::*;
#(
  parameter int FILT = DEF_FILT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise_nxt,
  output logic fall_nxt
);

  logic              sync_p0;
  logic              sync_p1;
  logic [FILT_W-1:0] cnt;
  logic              tgl;

  localparam logic [FILT_W-1:0] CNT_LAST = FILT_W'(FILT - 1);

  assign tgl      = (sync_p1 != level) && (cnt == CNT_LAST);
  assign rise_nxt = tgl &  sync_p1;
  assign fall_nxt = tgl & ~sync_p1;

  // Bring the asynchronous pin into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
    end
  end

  // Count disagreeing samples; toggle the level once enough accumulate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync_p1 == level) begin
      cnt <= '0;
    end else if (tgl) begin
      level <= sync_p1;
      cnt   <= '0;
    end else begin
      cnt <= cnt + FILT_W'(1);
    end
  end

endmodule

// File: rtl/map_cpu_sync.sv
// Cartridge CPU bus front-end: filters M2, tracks each 6502 bus cycle and
// emits single-clock strobes so mapper logic never clocks on raw M2.
module map_cpu_sync
  import map_cpu_sync_pkg::*;
#(
  parameter int FILT    = DEF_FILT,
  parameter int WR_DLY  = DEF_WR_DLY,
  parameter int IDLE_TO = DEF_IDLE_TO
) (
  input  logic           clk,
  input  logic           rst_n,
  map_cpu_sync_if.slave  bus
);

  localparam logic [DLY_W-1:0]  WR_LAST  = DLY_W'(WR_DLY - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TO);

  state_t            state;
  logic [DLY_W-1:0]  dly;
  logic [IDLE_W-1:0] idle_cnt;
  logic              m2_lvl;
  logic              rise_nxt;
  logic              fall_nxt;
  logic              cyc_start;

  sync_filt #(.FILT(FILT)) u_m2_filt (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (bus.pin_m2),
    .level    (m2_lvl),
    .rise_nxt (rise_nxt),
    .fall_nxt (fall_nxt)
  );

  assign bus.m2    = m2_lvl;
  assign cyc_start = (state == ST_LOW) && rise_nxt;

  // Bus-cycle tracker: latch address on rise, write data at the settle point
  // or at M2 fall if the cycle is shorter than WR_DLY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_LOW;
      dly          <= '0;
      bus.addr     <= '0;
      bus.rw       <= 1'b1;
      bus.data     <= '0;
      bus.m2_rise  <= 1'b0;
      bus.m2_fall  <= 1'b0;
      bus.wr_pulse <= 1'b0;
      bus.wr_early <= 1'b0;
    end else begin
      bus.m2_rise  <= 1'b0;
      bus.m2_fall  <= 1'b0;
      bus.wr_pulse <= 1'b0;
      bus.wr_early <= 1'b0;
      case (state)
        ST_LOW: begin
          if (rise_nxt) begin
            bus.m2_rise <= 1'b1;
            bus.addr    <= bus.pin_addr;
            bus.rw      <= bus.pin_rw;
            dly         <= '0;
            state       <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (fall_nxt) begin
            bus.m2_fall <= 1'b1;
            if (!bus.rw) begin
              bus.data     <= bus.pin_data;
              bus.wr_pulse <= 1'b1;
              bus.wr_early <= 1'b1;
            end
            state <= ST_LOW;
          end else if (!bus.rw && (dly == WR_LAST)) begin
            bus.data     <= bus.pin_data;
            bus.wr_pulse <= 1'b1;
            state        <= ST_HOLD;
          end else if (dly != WR_LAST) begin
            dly <= dly + DLY_W'(1);
          end
        end
        ST_HOLD: begin
          if (fall_nxt) begin
            bus.m2_fall <= 1'b1;
            state       <= ST_LOW;
          end
        end
        default: state <= ST_LOW;
      endcase
    end
  end

  // Watchdog on M2 activity; saturates so m2_lost stays a level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt    <= IDLE_MAX;
      bus.m2_lost <= 1'b1;
    end else if (cyc_start) begin
      idle_cnt    <= '0;
      bus.m2_lost <= 1'b0;
    end else if (idle_cnt != IDLE_MAX) begin
      idle_cnt    <= idle_cnt + IDLE_W'(1);
      bus.m2_lost <= ((idle_cnt + IDLE_W'(1)) == IDLE_MAX);
    end
  end

endmodule

// File: tb/tb_map_cpu_sync.sv
// Directed bench for the cartridge CPU bus front-end (FILT=2, WR_DLY=8,
// IDLE_TO=255). Inputs change on the falling edge; a monitor samples the
// outputs shortly after each rising edge and logs strobe positions.
module tb_map_cpu_sync;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  map_cpu_sync_if bus ();

  map_cpu_sync #(
    .FILT    (2),
    .WR_DLY  (8),
    .IDLE_TO (255)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   rise_n = 0, fall_n = 0, wr_n = 0;
  int   rise_at = 0, fall_at = 0, wr_at = 0, lost_at = 0;
  logic early_seen = 1'b0;
  logic lost_prev = 1'b0;
  int   r0, f0, w0;
  int   t_rise_pin, t_fall_pin, t_rel, r_last;

  // Strobe logger
  always @(posedge clk) begin
    #2;
    cyc++;
    if (bus.m2_rise)  begin rise_n++; rise_at = cyc; end
    if (bus.m2_fall)  begin fall_n++; fall_at = cyc; end
    if (bus.wr_pulse) begin wr_n++; wr_at = cyc; early_seen = bus.wr_early; end
    if (bus.m2_lost && !lost_prev) lost_at = cyc;
    lost_prev = bus.m2_lost;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    r0 = rise_n;
    f0 = fall_n;
    w0 = wr_n;
  endtask

  task automatic bus_cycle(input logic r, input logic [15:0] a, input logic [7:0] d, input int hi);
    bus.pin_rw   = r;
    bus.pin_addr = a;
    bus.pin_data = d;
    step(1);
    bus.pin_m2 = 1'b1;
    t_rise_pin = cyc;
    step(hi);
    bus.pin_m2 = 1'b0;
    t_fall_pin = cyc;
    step(8);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.pin_m2   = 1'b0;
    bus.pin_rw   = 1'b1;
    bus.pin_addr = 16'h0000;
    bus.pin_data = 8'h00;
    step(3);

    // Reset state
    check("rst_m2",    32'(bus.m2),       32'h0);
    check("rst_addr",  32'(bus.addr),     32'h0);
    check("rst_rw",    32'(bus.rw),       32'h1);
    check("rst_data",  32'(bus.data),     32'h0);
    check("rst_lost",  32'(bus.m2_lost),  32'h1);
    check("rst_rise",  32'(bus.m2_rise),  32'h0);
    check("rst_wr",    32'(bus.wr_pulse), 32'h0);
    check("rst_early", 32'(bus.wr_early), 32'h0);
    rst_n = 1'b1;
    step(2);

    // Read cycle
    snap();
    bus_cycle(1'b1, 16'h8000, 8'hFF, 20);
    check("rd_rises",   32'(rise_n - r0), 32'd1);
    check("rd_falls",   32'(fall_n - f0), 32'd1);
    check("rd_wr",      32'(wr_n - w0),   32'd0);
    check("rd_addr",    32'(bus.addr),    32'h8000);
    check("rd_rw",      32'(bus.rw),      32'h1);
    check("rd_rise_lat", 32'(rise_at - t_rise_pin), 32'd4);
    check("rd_fall_lat", 32'(fall_at - t_fall_pin), 32'd4);
    check("rd_lost",    32'(bus.m2_lost), 32'h0);

    // Normal write
    snap();
    bus_cycle(1'b0, 16'h6001, 8'h5A, 20);
    check("wr_count",  32'(wr_n - w0),      32'd1);
    check("wr_delay",  32'(wr_at - rise_at), 32'd8);
    check("wr_data",   32'(bus.data),       32'h5A);
    check("wr_early",  32'(early_seen),     32'h0);
    check("wr_addr",   32'(bus.addr),       32'h6001);
    check("wr_rw",     32'(bus.rw),         32'h0);
    check("wr_falls",  32'(fall_n - f0),    32'd1);

    // Short write: data captured at M2 fall
    snap();
    bus_cycle(1'b0, 16'h6002, 8'hC3, 5);
    check("ew_count",  32'(wr_n - w0),   32'd1);
    check("ew_early",  32'(early_seen),  32'h1);
    check("ew_coinc",  32'(wr_at - fall_at), 32'd0);
    check("ew_data",   32'(bus.data),    32'hC3);
    check("ew_falls",  32'(fall_n - f0), 32'd1);

    // One-clock high glitch
    snap();
    bus.pin_m2 = 1'b1;
    step(1);
    bus.pin_m2 = 1'b0;
    step(8);
    check("gh_rises", 32'(rise_n - r0), 32'd0);
    check("gh_falls", 32'(fall_n - f0), 32'd0);

    // Read cycle with a one-clock low glitch in the high phase
    snap();
    bus.pin_rw   = 1'b1;
    bus.pin_addr = 16'h9000;
    step(1);
    bus.pin_m2 = 1'b1;
    step(10);
    bus.pin_m2 = 1'b0;
    step(1);
    bus.pin_m2 = 1'b1;
    step(10);
    bus.pin_m2 = 1'b0;
    step(8);
    check("gl_rises", 32'(rise_n - r0), 32'd1);
    check("gl_falls", 32'(fall_n - f0), 32'd1);
    check("gl_addr",  32'(bus.addr),    32'h9000);
    r_last = rise_at;

    // M2 stopped
    step(300);
    check("idle_lost",    32'(bus.m2_lost),      32'h1);
    check("idle_lost_at", 32'(lost_at - r_last), 32'd255);

    // Resume: lost clears in the m2_rise clock
    bus.pin_rw   = 1'b1;
    bus.pin_addr = 16'hA000;
    step(1);
    bus.pin_m2 = 1'b1;
    step(3);
    check("res_pre_rise", 32'(bus.m2_rise), 32'h0);
    check("res_pre_lost", 32'(bus.m2_lost), 32'h1);
    step(1);
    check("res_rise",     32'(bus.m2_rise), 32'h1);
    check("res_lost",     32'(bus.m2_lost), 32'h0);
    step(10);
    bus.pin_m2 = 1'b0;
    step(8);

    // Reset while in HOLD with M2 still high
    bus.pin_rw   = 1'b0;
    bus.pin_addr = 16'h6003;
    bus.pin_data = 8'h77;
    step(1);
    bus.pin_m2 = 1'b1;
    step(14);
    check("hold_data", 32'(bus.data), 32'h77);
    rst_n = 1'b0;
    #1;
    check("hrst_m2",   32'(bus.m2),      32'h0);
    check("hrst_addr", 32'(bus.addr),    32'h0);
    check("hrst_rw",   32'(bus.rw),      32'h1);
    check("hrst_data", 32'(bus.data),    32'h0);
    check("hrst_lost", 32'(bus.m2_lost), 32'h1);
    bus.pin_rw   = 1'b1;
    bus.pin_addr = 16'h7123;
    step(2);
    rst_n = 1'b1;
    t_rel = cyc;
    snap();
    step(6);
    check("hrel_rises", 32'(rise_n - r0),    32'd1);
    check("hrel_lat",   32'(rise_at - t_rel), 32'd4);
    check("hrel_addr",  32'(bus.addr),       32'h7123);
    check("hrel_rw",    32'(bus.rw),         32'h1);
    bus.pin_m2 = 1'b0;
    step(8);
    check("hrel_falls", 32'(fall_n - f0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
